// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS control unit: decodes the IR and sequences FETCH/DECODE/EXEC/MEM/WB.
// Optional overflow trap for add/sub/addi is enabled by defining OVERFLOW_TRAP_EN.
`timescale 1ns/1ps
module mc_control_fsm #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] instr,
  input  logic        alu_zero,
  input  logic        alu_ovf,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic        iord,
  output logic        ir_we,
  output logic        pc_we,
  output logic        reg_we,
  output logic [3:0]  aluc,
  output logic [1:0]  alu_a_sel,
  output logic [1:0]  alu_b_sel,
  output logic        ext_sign,
  output logic [1:0]  reg_dst,
  output logic [1:0]  wb_sel,
  output logic [1:0]  pc_src,
  output logic        instr_done,
  output logic        illegal,
  output logic        bus_err
`ifdef OVERFLOW_TRAP_EN
  ,output logic       exc
`endif
);

  localparam logic [3:0] ALU_ADDU = 4'b0000;
  localparam logic [3:0] ALU_SUBU = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0011;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0110;
  localparam logic [3:0] ALU_NOR  = 4'b0111;
  localparam logic [3:0] ALU_LUI  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1010;
  localparam logic [3:0] ALU_SLT  = 4'b1011;
  localparam logic [3:0] ALU_SRA  = 4'b1100;
  localparam logic [3:0] ALU_SRL  = 4'b1101;
  localparam logic [3:0] ALU_SLL  = 4'b1110;

  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_e;

  typedef enum logic [3:0] {
    C_ILL, C_RALU, C_SHIFT, C_IALU, C_LW, C_SW,
    C_BEQ, C_BNE, C_J, C_JAL, C_JR
  } iclass_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout;

  iclass_e    cls;
  logic [3:0] dec_aluc;
  logic       dec_sext;
  logic       dec_ovf_chk;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_ok;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];

  // Instruction decode; only meaningful from DECODE onward.
  // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    cls         = C_ILL;
    dec_aluc    = ALU_ADDU;
    dec_sext    = 1'b0;
    dec_ovf_chk = 1'b0;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h00: begin cls = C_SHIFT; dec_aluc = ALU_SLL; end
          6'h02: begin cls = C_SHIFT; dec_aluc = ALU_SRL; end
          6'h03: begin cls = C_SHIFT; dec_aluc = ALU_SRA; end
          6'h04: begin cls = C_RALU;  dec_aluc = ALU_SLL; end
          6'h06: begin cls = C_RALU;  dec_aluc = ALU_SRL; end
          6'h07: begin cls = C_RALU;  dec_aluc = ALU_SRA; end
          6'h08: cls = C_JR;
          6'h20: begin cls = C_RALU; dec_aluc = ALU_ADD; dec_ovf_chk = 1'b1; end
          6'h21: begin cls = C_RALU; dec_aluc = ALU_ADDU; end
          6'h22: begin cls = C_RALU; dec_aluc = ALU_SUB; dec_ovf_chk = 1'b1; end
          6'h23: begin cls = C_RALU; dec_aluc = ALU_SUBU; end
          6'h24: begin cls = C_RALU; dec_aluc = ALU_AND; end
          6'h25: begin cls = C_RALU; dec_aluc = ALU_OR; end
          6'h26: begin cls = C_RALU; dec_aluc = ALU_XOR; end
          6'h27: begin cls = C_RALU; dec_aluc = ALU_NOR; end
          6'h2A: begin cls = C_RALU; dec_aluc = ALU_SLT; end
          6'h2B: begin cls = C_RALU; dec_aluc = ALU_SLTU; end
          default: cls = C_ILL;
        endcase
      end
      6'h02: cls = C_J;
      6'h03: cls = C_JAL;
      6'h04: begin cls = C_BEQ; dec_aluc = ALU_SUBU; end
      6'h05: begin cls = C_BNE; dec_aluc = ALU_SUBU; end
      6'h08: begin cls = C_IALU; dec_aluc = ALU_ADD; dec_sext = 1'b1; dec_ovf_chk = 1'b1; end
      6'h09: begin cls = C_IALU; dec_aluc = ALU_ADDU; dec_sext = 1'b1; end
      6'h0A: begin cls = C_IALU; dec_aluc = ALU_SLT; dec_sext = 1'b1; end
      6'h0B: begin cls = C_IALU; dec_aluc = ALU_SLTU; dec_sext = 1'b1; end
      6'h0C: begin cls = C_IALU; dec_aluc = ALU_AND; end
      6'h0D: begin cls = C_IALU; dec_aluc = ALU_OR; end
      6'h0E: begin cls = C_IALU; dec_aluc = ALU_XOR; end
      6'h0F: begin cls = C_IALU; dec_aluc = ALU_LUI; end
      6'h23: begin cls = C_LW; dec_aluc = ALU_ADDU; dec_sext = 1'b1; end
      6'h2B: begin cls = C_SW; dec_aluc = ALU_ADDU; dec_sext = 1'b1; end
      default: cls = C_ILL;
    endcase
  end

  assign timeout = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES));

  // Next state and strobes; everything is held at its idle value while rstn is low.
  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    reg_we     = 1'b0;
    aluc       = ALU_ADDU;
    alu_a_sel  = 2'd0;
    alu_b_sel  = 2'd0;
    ext_sign   = 1'b0;
    reg_dst    = 2'd0;
    wb_sel     = 2'd0;
    pc_src     = 2'd0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    bus_err    = 1'b0;
    if (rstn) begin
      case (state_q)
        S_FETCH: begin
          alu_b_sel = 2'd1;
          if (timeout) begin
            bus_err = 1'b1;
          end else begin
            mem_req = 1'b1;
            if (mem_ack) begin
              ir_we   = 1'b1;
              pc_we   = 1'b1;
              state_d = S_DECODE;
            end
          end
        end
        S_DECODE: begin
          alu_b_sel = 2'd3;
          ext_sign  = 1'b1;
          if (cls == C_ILL) begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_EXEC;
          end
        end
        S_EXEC: begin
          aluc     = dec_aluc;
          ext_sign = dec_sext;
          state_d  = S_FETCH;
          case (cls)
            C_RALU: begin
              alu_a_sel = 2'd1;
              state_d   = S_WB;
            end
            C_SHIFT: begin
              alu_a_sel = 2'd2;
              state_d   = S_WB;
            end
            C_IALU: begin
              alu_a_sel = 2'd1;
              alu_b_sel = 2'd2;
              state_d   = S_WB;
            end
            C_LW, C_SW: begin
              alu_a_sel = 2'd1;
              alu_b_sel = 2'd2;
              state_d   = S_MEM;
            end
            C_BEQ, C_BNE: begin
              alu_a_sel  = 2'd1;
              pc_src     = 2'd1;
              pc_we      = (cls == C_BEQ) ? alu_zero : !alu_zero;
              instr_done = 1'b1;
            end
            C_J: begin
              pc_we      = 1'b1;
              pc_src     = 2'd2;
              instr_done = 1'b1;
            end
            C_JAL: begin
              pc_we      = 1'b1;
              pc_src     = 2'd2;
              reg_we     = 1'b1;
              reg_dst    = 2'd2;
              wb_sel     = 2'd2;
              instr_done = 1'b1;
            end
            C_JR: begin
              pc_we      = 1'b1;
              pc_src     = 2'd3;
              instr_done = 1'b1;
            end
            default: state_d = S_FETCH;
          endcase
`ifdef OVERFLOW_TRAP_EN
          if (dec_ovf_chk && alu_ovf) state_d = S_TRAP;
`endif
        end
        S_MEM: begin
          if (timeout) begin
            bus_err = 1'b1;
            state_d = S_FETCH;
          end else begin
            mem_req = 1'b1;
            iord    = 1'b1;
            mem_we  = (cls == C_SW);
            if (mem_ack) begin
              if (cls == C_SW) begin
                instr_done = 1'b1;
                state_d    = S_FETCH;
              end else begin
                state_d = S_WB;
              end
            end
          end
        end
        S_WB: begin
          reg_we     = 1'b1;
          instr_done = 1'b1;
          reg_dst    = (cls == C_RALU || cls == C_SHIFT) ? 2'd1 : 2'd0;
          wb_sel     = (cls == C_LW) ? 2'd1 : 2'd0;
          state_d    = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  // Wait counter: runs only while a request is outstanding, restarts on ack, timeout or any state change.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q || (mem_req && mem_ack) || timeout) begin
      cnt_d = '0;
    end else if (mem_req && TIMEOUT_CYCLES != 0) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef OVERFLOW_TRAP_EN
  assign exc       = rstn && (state_q == S_TRAP);
  assign unused_ok = &{1'b0, instr[25:6]};
`else
  assign unused_ok = &{1'b0, instr[25:6], alu_ovf, dec_ovf_chk};
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: per-cycle stimulus and hand-derived strobe vectors.
// Runs with TIMEOUT_CYCLES=4; trap expectations follow OVERFLOW_TRAP_EN.
`timescale 1ns/1ps
module tb_mc_control_fsm;

  typedef struct packed {
    logic       mem_req, mem_we, iord, ir_we, pc_we, reg_we;
    logic [3:0] aluc;
    logic [1:0] a_sel, b_sel;
    logic       ext_sign;
    logic [1:0] reg_dst, wb_sel, pc_src;
    logic       instr_done, illegal, bus_err, exc;
  } ctl_t;

  typedef struct packed {
    logic        ack, zero, ovf;
    logic [31:0] instr;
  } stim_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] instr = '0;
  logic        alu_zero = 1'b0, alu_ovf = 1'b0, mem_ack = 1'b0;
  logic        mem_req, mem_we, iord, ir_we, pc_we, reg_we;
  logic [3:0]  aluc;
  logic [1:0]  alu_a_sel, alu_b_sel, reg_dst, wb_sel, pc_src;
  logic        ext_sign, instr_done, illegal, bus_err, exc;

  int checks = 0;
  int failures = 0;
  ctl_t  exp_q[$];
  stim_t stim_q[$];
  logic [31:0] cur_instr;

  always #5 clk = ~clk;

  mc_control_fsm #(.TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .instr      (instr),
    .alu_zero   (alu_zero),
    .alu_ovf    (alu_ovf),
    .mem_ack    (mem_ack),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .iord       (iord),
    .ir_we      (ir_we),
    .pc_we      (pc_we),
    .reg_we     (reg_we),
    .aluc       (aluc),
    .alu_a_sel  (alu_a_sel),
    .alu_b_sel  (alu_b_sel),
    .ext_sign   (ext_sign),
    .reg_dst    (reg_dst),
    .wb_sel     (wb_sel),
    .pc_src     (pc_src),
    .instr_done (instr_done),
    .illegal    (illegal),
    .bus_err    (bus_err)
`ifdef OVERFLOW_TRAP_EN
    ,.exc       (exc)
`endif
  );

`ifndef OVERFLOW_TRAP_EN
  assign exc = 1'b0;
`endif

  ctl_t obs;
  assign obs = {mem_req, mem_we, iord, ir_we, pc_we, reg_we, aluc, alu_a_sel, alu_b_sel,
                ext_sign, reg_dst, wb_sel, pc_src, instr_done, illegal, bus_err, exc};

  // Expected strobe vectors for each phase.
  function automatic ctl_t fetch_c(input logic ack);
    ctl_t c = '0;
    c.mem_req = 1'b1; c.b_sel = 2'd1; c.ir_we = ack; c.pc_we = ack;
    return c;
  endfunction

  function automatic ctl_t decode_c();
    ctl_t c = '0;
    c.b_sel = 2'd3; c.ext_sign = 1'b1;
    return c;
  endfunction

  function automatic ctl_t exec_c(input logic [3:0] op, input logic [1:0] a, input logic [1:0] b,
                                  input logic sext);
    ctl_t c = '0;
    c.aluc = op; c.a_sel = a; c.b_sel = b; c.ext_sign = sext;
    return c;
  endfunction

  function automatic ctl_t wb_c(input logic [1:0] dst, input logic [1:0] sel);
    ctl_t c = '0;
    c.reg_we = 1'b1; c.instr_done = 1'b1; c.reg_dst = dst; c.wb_sel = sel;
    return c;
  endfunction

  function automatic ctl_t mem_c(input logic we, input logic ack);
    ctl_t c = '0;
    c.mem_req = 1'b1; c.iord = 1'b1; c.mem_we = we; c.instr_done = we & ack;
    return c;
  endfunction

  function automatic logic [31:0] r_instr(input logic [5:0] f);
    return {6'h00, 5'd1, 5'd2, 5'd3, 5'd4, f};
  endfunction

  function automatic logic [31:0] i_instr(input logic [5:0] op);
    return {op, 5'd1, 5'd2, 16'h8001};
  endfunction

  task automatic push(input ctl_t e, input logic ack, input logic zero = 1'b0, input logic ovf = 1'b0);
    exp_q.push_back(e);
    stim_q.push_back({ack, zero, ovf, cur_instr});
  endtask

  task automatic apply(input int i);
    mem_ack  = stim_q[i].ack;
    alu_zero = stim_q[i].zero;
    alu_ovf  = stim_q[i].ovf;
    instr    = stim_q[i].instr;
  endtask

  // Leaves the DUT in FETCH with a clear wait counter, 1 ns after a rising edge.
  task automatic do_reset();
    exp_q.delete();
    stim_q.delete();
    rstn = 1'b0; mem_ack = 1'b0; alu_zero = 1'b0; alu_ovf = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; mem_ack = 1'b1; alu_zero = 1'b1; alu_ovf = 1'b1; instr = i_instr(6'h23);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== ctl_t'('0)) begin
        failures++;
        $display("FAIL reset_idle cyc%0d got=%h exp=%h", i + 1, obs, ctl_t'('0));
      end
      @(posedge clk); #1;
    end
    rstn = 1'b1; mem_ack = 1'b0; alu_zero = 1'b0; alu_ovf = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== fetch_c(1'b0)) begin
      failures++;
      $display("FAIL reset_first_fetch got=%h exp=%h", obs, fetch_c(1'b0));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_r_alu();
    logic [5:0] fn [6] = '{6'h21, 6'h22, 6'h2A, 6'h00, 6'h07, 6'h27};
    logic [3:0] op [6] = '{4'b0000, 4'b0011, 4'b1011, 4'b1110, 4'b1100, 4'b0111};
    logic [1:0] as [6] = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd1, 2'd1};
    for (int k = 0; k < 6; k++) begin
      do_reset();
      cur_instr = r_instr(fn[k]);
      push(fetch_c(1'b1), 1'b1);
      push(decode_c(), 1'b0);
      push(exec_c(op[k], as[k], 2'd0, 1'b0), 1'b0);
      push(wb_c(2'd1, 2'd0), 1'b0);
      push(fetch_c(1'b0), 1'b0);
      for (int i = 0; i < exp_q.size(); i++) begin
        apply(i);
        @(negedge clk);
        checks++;
        if (obs !== exp_q[i]) begin
          failures++;
          $display("FAIL r_alu_f%02h cyc%0d got=%h exp=%h", fn[k], i + 1, obs, exp_q[i]);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_i_alu();
    logic [5:0] opc [3] = '{6'h08, 6'h0D, 6'h0A};
    logic [3:0] op  [3] = '{4'b0010, 4'b0101, 4'b1011};
    logic       sx  [3] = '{1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 3; k++) begin
      do_reset();
      cur_instr = i_instr(opc[k]);
      push(fetch_c(1'b1), 1'b1);
      push(decode_c(), 1'b0);
      push(exec_c(op[k], 2'd1, 2'd2, sx[k]), 1'b0);
      push(wb_c(2'd0, 2'd0), 1'b0);
      push(fetch_c(1'b0), 1'b0);
      for (int i = 0; i < exp_q.size(); i++) begin
        apply(i);
        @(negedge clk);
        checks++;
        if (obs !== exp_q[i]) begin
          failures++;
          $display("FAIL i_alu_op%02h cyc%0d got=%h exp=%h", opc[k], i + 1, obs, exp_q[i]);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_branch();
    logic [5:0] opc  [4] = '{6'h04, 6'h04, 6'h05, 6'h05};
    logic       zero [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic       take [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    ctl_t       e;
    for (int k = 0; k < 4; k++) begin
      do_reset();
      cur_instr = i_instr(opc[k]);
      e = exec_c(4'b0001, 2'd1, 2'd0, 1'b0);
      e.pc_src = 2'd1; e.pc_we = take[k]; e.instr_done = 1'b1;
      push(fetch_c(1'b1), 1'b1);
      push(decode_c(), 1'b0);
      push(e, 1'b0, zero[k]);
      push(fetch_c(1'b0), 1'b0);
      for (int i = 0; i < exp_q.size(); i++) begin
        apply(i);
        @(negedge clk);
        checks++;
        if (obs !== exp_q[i]) begin
          failures++;
          $display("FAIL branch%0d cyc%0d got=%h exp=%h", k, i + 1, obs, exp_q[i]);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_jump();
    ctl_t e;
    for (int k = 0; k < 3; k++) begin
      do_reset();
      e = '0; e.pc_we = 1'b1; e.instr_done = 1'b1;
      case (k)
        0: begin cur_instr = i_instr(6'h02); e.pc_src = 2'd2; end
        1: begin
          cur_instr = i_instr(6'h03); e.pc_src = 2'd2;
          e.reg_we = 1'b1; e.reg_dst = 2'd2; e.wb_sel = 2'd2;
        end
        default: begin cur_instr = r_instr(6'h08); e.pc_src = 2'd3; end
      endcase
      push(fetch_c(1'b1), 1'b1);
      push(decode_c(), 1'b0);
      push(e, 1'b0);
      push(fetch_c(1'b0), 1'b0);
      for (int i = 0; i < exp_q.size(); i++) begin
        apply(i);
        @(negedge clk);
        checks++;
        if (obs !== exp_q[i]) begin
          failures++;
          $display("FAIL jump%0d cyc%0d got=%h exp=%h", k, i + 1, obs, exp_q[i]);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_lw_wait();
    do_reset();
    cur_instr = i_instr(6'h23);
    push(fetch_c(1'b1), 1'b1);
    push(decode_c(), 1'b0);
    push(exec_c(4'b0000, 2'd1, 2'd2, 1'b1), 1'b0);
    for (int w = 0; w < 3; w++) push(mem_c(1'b0, 1'b0), 1'b0);
    push(mem_c(1'b0, 1'b1), 1'b1);
    push(wb_c(2'd0, 2'd1), 1'b0);
    push(fetch_c(1'b0), 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      apply(i);
      @(negedge clk);
      checks++;
      if (obs !== exp_q[i]) begin
        failures++;
        $display("FAIL lw_wait cyc%0d got=%h exp=%h", i + 1, obs, exp_q[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sw();
    do_reset();
    cur_instr = i_instr(6'h2B);
    push(fetch_c(1'b1), 1'b1);
    push(decode_c(), 1'b1);
    push(exec_c(4'b0000, 2'd1, 2'd2, 1'b1), 1'b1);
    push(mem_c(1'b1, 1'b0), 1'b0);
    push(mem_c(1'b1, 1'b1), 1'b1);
    push(fetch_c(1'b0), 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      apply(i);
      @(negedge clk);
      checks++;
      if (obs !== exp_q[i]) begin
        failures++;
        $display("FAIL sw cyc%0d got=%h exp=%h", i + 1, obs, exp_q[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    ctl_t e;
    for (int k = 0; k < 2; k++) begin
      do_reset();
      cur_instr = i_instr(6'h2B);
      e = '0; e.bus_err = 1'b1;
      if (k == 0) begin
        for (int w = 0; w < 4; w++) push(fetch_c(1'b0), 1'b0);
        e.b_sel = 2'd1;
      end else begin
        push(fetch_c(1'b1), 1'b1);
        push(decode_c(), 1'b0);
        push(exec_c(4'b0000, 2'd1, 2'd2, 1'b1), 1'b0);
        for (int w = 0; w < 4; w++) push(mem_c(1'b1, 1'b0), 1'b0);
      end
      push(e, 1'b0);
      push(fetch_c(1'b0), 1'b0);
      for (int i = 0; i < exp_q.size(); i++) begin
        apply(i);
        @(negedge clk);
        checks++;
        if (obs !== exp_q[i]) begin
          failures++;
          $display("FAIL timeout%0d cyc%0d got=%h exp=%h", k, i + 1, obs, exp_q[i]);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_illegal();
    ctl_t e;
    for (int k = 0; k < 2; k++) begin
      do_reset();
      cur_instr = (k == 0) ? {6'h3F, 26'h0} : r_instr(6'h01);
      e = decode_c(); e.illegal = 1'b1;
      push(fetch_c(1'b1), 1'b1);
      push(e, 1'b0);
      push(fetch_c(1'b0), 1'b0);
      for (int i = 0; i < exp_q.size(); i++) begin
        apply(i);
        @(negedge clk);
        checks++;
        if (obs !== exp_q[i]) begin
          failures++;
          $display("FAIL illegal%0d cyc%0d got=%h exp=%h", k, i + 1, obs, exp_q[i]);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset_mid_sw();
    do_reset();
    cur_instr = i_instr(6'h2B);
    push(fetch_c(1'b1), 1'b1);
    push(decode_c(), 1'b0);
    push(exec_c(4'b0000, 2'd1, 2'd2, 1'b1), 1'b0);
    push(mem_c(1'b1, 1'b0), 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      apply(i);
      @(negedge clk);
      checks++;
      if (obs !== exp_q[i]) begin
        failures++;
        $display("FAIL reset_mid cyc%0d got=%h exp=%h", i + 1, obs, exp_q[i]);
      end
      @(posedge clk); #1;
    end
    rstn = 1'b0; mem_ack = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== ctl_t'('0)) begin
      failures++;
      $display("FAIL reset_mid_hold got=%h exp=%h", obs, ctl_t'('0));
    end
    @(posedge clk); #1;
    rstn = 1'b1; mem_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== fetch_c(1'b0)) begin
      failures++;
      $display("FAIL reset_mid_refetch got=%h exp=%h", obs, fetch_c(1'b0));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    do_reset();
    cur_instr = r_instr(6'h21);
    push(fetch_c(1'b1), 1'b1);
    push(decode_c(), 1'b1);
    push(exec_c(4'b0000, 2'd1, 2'd0, 1'b0), 1'b1);
    push(wb_c(2'd1, 2'd0), 1'b1);
    cur_instr = i_instr(6'h0D);
    push(fetch_c(1'b1), 1'b1);
    push(decode_c(), 1'b1);
    push(exec_c(4'b0101, 2'd1, 2'd2, 1'b0), 1'b1);
    push(wb_c(2'd0, 2'd0), 1'b1);
    push(fetch_c(1'b1), 1'b1);
    for (int i = 0; i < exp_q.size(); i++) begin
      apply(i);
      @(negedge clk);
      checks++;
      if (obs !== exp_q[i]) begin
        failures++;
        $display("FAIL back_to_back cyc%0d got=%h exp=%h", i + 1, obs, exp_q[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_overflow();
    ctl_t e;
    for (int k = 0; k < 2; k++) begin
      do_reset();
      cur_instr = (k == 0) ? r_instr(6'h20) : r_instr(6'h21);
      push(fetch_c(1'b1), 1'b1);
      push(decode_c(), 1'b0);
      push(exec_c((k == 0) ? 4'b0010 : 4'b0000, 2'd1, 2'd0, 1'b0), 1'b0, 1'b0, 1'b1);
`ifdef OVERFLOW_TRAP_EN
      if (k == 0) begin
        e = '0; e.exc = 1'b1;
      end else begin
        e = wb_c(2'd1, 2'd0);
      end
`else
      e = wb_c(2'd1, 2'd0);
`endif
      push(e, 1'b0);
      push(fetch_c(1'b0), 1'b0);
      for (int i = 0; i < exp_q.size(); i++) begin
        apply(i);
        @(negedge clk);
        checks++;
        if (obs !== exp_q[i]) begin
          failures++;
          $display("FAIL overflow%0d cyc%0d got=%h exp=%h", k, i + 1, obs, exp_q[i]);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_r_alu();
    test_i_alu();
    test_branch();
    test_jump();
    test_lw_wait();
    test_sw();
    test_timeout();
    test_illegal();
    test_reset_mid_sw();
    test_back_to_back();
    test_overflow();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
